// File: rtl/jtcop_pal_sched.sv
// Palette write scheduler: buffers CPU palette writes in a FIFO and commits
// them to the colour-mix palette RAM write port only while the screen is blanked.
module jtcop_pal_sched #(
    parameter int AW     = 4,
    parameter int HBL_EN = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          LVBL,
    input  logic          LHBL,
    input  logic          cpu_we,
    input  logic          cpu_bank,
    input  logic [9:0]    cpu_addr,
    input  logic [15:0]   cpu_dout,
    input  logic [1:0]    dsn,
    output logic          full,
    output logic          ovf,
    output logic [AW:0]   pending,
    output logic [9:0]    pal_addr,
    output logic [15:0]   pal_data,
    output logic [1:0]    pal_we_gr,
    output logic          pal_we_b
);

    localparam int          DEPTH   = 2**AW;
    localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};
    localparam logic        HBL_ON  = (HBL_EN != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic        bank;
        logic [9:0]  addr;
        logic [15:0] data;
        logic [1:0]  dsn;
    } entry_t;

    // Byte enables for one entry: {blue, red/green[1:0]}. dsn=11 yields none.
    function automatic logic [2:0] we_decode(input entry_t e);
        logic [2:0] we;
        we[1:0] = ~e.dsn & {2{~e.bank}};
        we[2]   = ~e.dsn[0] & e.bank;
        return we;
    endfunction

    state_t          r_state;
    logic [AW:0]     r_count;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic            r_ovf;
    entry_t          r_mem [DEPTH];

    logic [9:0]      r_addr_p1;
    logic [15:0]     r_data_p1;
    logic [1:0]      r_we_gr_p1;
    logic            r_we_b_p1;

    logic            w_blank;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    entry_t          w_wr_p0;
    entry_t          w_rd_p0;
    logic [2:0]      w_we_p0;

    assign w_blank = ~LVBL | (HBL_ON & ~LHBL);
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);

    // A write arriving on a full FIFO is lost even if a pop frees a slot this cycle.
    assign w_push  = cpu_we & ~w_full;
    assign w_pop   = (r_state == ST_DRAIN) & w_blank & ~w_empty;

    assign w_wr_p0 = {cpu_bank, cpu_addr, cpu_dout, dsn};
    assign w_rd_p0 = r_mem[r_rptr];
    assign w_we_p0 = we_decode(w_rd_p0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_wr_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (cpu_we && w_full) begin
                r_ovf <= 1'b1;
            end
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) r_state <= ST_ARM;
                end
                ST_ARM: begin
                    if (w_blank) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_empty && !w_push) r_state <= ST_IDLE;
                    else if (!w_blank)      r_state <= ST_ARM;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // p0 -> p1: popped entry registered onto the palette write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_p1  <= '0;
            r_data_p1  <= '0;
            r_we_gr_p1 <= '0;
            r_we_b_p1  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_addr_p1 <= w_rd_p0.addr;
                r_data_p1 <= w_rd_p0.data;
            end
            r_we_gr_p1 <= w_pop ? w_we_p0[1:0] : 2'b00;
            r_we_b_p1  <= w_pop & w_we_p0[2];
        end
    end

    assign full      = w_full;
    assign ovf       = r_ovf;
    assign pending   = r_count;
    assign pal_addr  = r_addr_p1;
    assign pal_data  = r_data_p1;
    assign pal_we_gr = r_we_gr_p1;
    assign pal_we_b  = r_we_b_p1;

endmodule

// File: tb/tb_jtcop_pal_sched.sv
// Bench for jtcop_pal_sched: two instances (vertical-blank only, and with
// horizontal blank) checked every cycle against a queue-based model.
module tb_jtcop_pal_sched;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic        bank;
        logic [9:0]  addr;
        logic [15:0] data;
        logic [1:0]  dsn;
    } ent_t;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        LVBL     = 1'b1;
    logic        LHBL     = 1'b1;
    logic        cpu_we   = 1'b0;
    logic        cpu_bank = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [15:0] cpu_dout = '0;
    logic [1:0]  dsn      = '0;

    logic [1:0]  full_v;
    logic [1:0]  ovf_v;
    logic [1:0]  pb_v;
    logic [AW:0] pend_v  [2];
    logic [9:0]  paddr_v [2];
    logic [15:0] pdata_v [2];
    logic [1:0]  pgr_v   [2];

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    jtcop_pal_sched #(.AW(AW), .HBL_EN(0)) u_dut_v (
        .clk(clk), .rst_n(rst_n), .LVBL(LVBL), .LHBL(LHBL),
        .cpu_we(cpu_we), .cpu_bank(cpu_bank), .cpu_addr(cpu_addr),
        .cpu_dout(cpu_dout), .dsn(dsn),
        .full(full_v[0]), .ovf(ovf_v[0]), .pending(pend_v[0]),
        .pal_addr(paddr_v[0]), .pal_data(pdata_v[0]),
        .pal_we_gr(pgr_v[0]), .pal_we_b(pb_v[0])
    );

    jtcop_pal_sched #(.AW(AW), .HBL_EN(1)) u_dut_h (
        .clk(clk), .rst_n(rst_n), .LVBL(LVBL), .LHBL(LHBL),
        .cpu_we(cpu_we), .cpu_bank(cpu_bank), .cpu_addr(cpu_addr),
        .cpu_dout(cpu_dout), .dsn(dsn),
        .full(full_v[1]), .ovf(ovf_v[1]), .pending(pend_v[1]),
        .pal_addr(paddr_v[1]), .pal_data(pdata_v[1]),
        .pal_we_gr(pgr_v[1]), .pal_we_b(pb_v[1])
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    ent_t        mq [2][$];
    int          m_mode [2];   // 0 empty/idle, 1 waiting for blank, 2 draining
    logic        m_ovf  [2];
    logic [9:0]  m_addr [2];
    logic [15:0] m_data [2];
    logic [1:0]  m_gr   [2];
    logic        m_b    [2];
    logic        m_blank;
    logic        m_pop;
    logic        m_push;
    int          m_cnt;
    ent_t        m_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                mq[d].delete();
                m_mode[d] = 0;
                m_ovf[d]  = 1'b0;
                m_addr[d] = '0;
                m_data[d] = '0;
                m_gr[d]   = 2'b00;
                m_b[d]    = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_blank = !LVBL || (d == 1 && !LHBL);
                m_cnt   = mq[d].size();
                m_pop   = (m_mode[d] == 2) && m_blank && (m_cnt > 0);
                m_push  = cpu_we && (m_cnt < DEPTH);
                if (cpu_we && !m_push) m_ovf[d] = 1'b1;
                m_gr[d] = 2'b00;
                m_b[d]  = 1'b0;
                if (m_pop) begin
                    m_e       = mq[d].pop_front();
                    m_addr[d] = m_e.addr;
                    m_data[d] = m_e.data;
                    if (m_e.bank) m_b[d]  = !m_e.dsn[0];
                    else          m_gr[d] = ~m_e.dsn;
                end
                if (m_push) begin
                    m_e = {cpu_bank, cpu_addr, cpu_dout, dsn};
                    mq[d].push_back(m_e);
                end
                case (m_mode[d])
                    0: if (m_cnt > 0) m_mode[d] = 1;
                    1: if (m_blank) m_mode[d] = 2;
                    default: begin
                        if (m_cnt == 0 && !m_push) m_mode[d] = 0;
                        else if (!m_blank)         m_mode[d] = 1;
                    end
                endcase
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("pending[%0d]", d), 32'(pend_v[d]), 32'(mq[d].size()));
                chk($sformatf("full[%0d]", d), 32'(full_v[d]), 32'(mq[d].size() == DEPTH));
                chk($sformatf("ovf[%0d]", d), 32'(ovf_v[d]), 32'(m_ovf[d]));
                chk($sformatf("pal_addr[%0d]", d), 32'(paddr_v[d]), 32'(m_addr[d]));
                chk($sformatf("pal_data[%0d]", d), 32'(pdata_v[d]), 32'(m_data[d]));
                chk($sformatf("pal_we_gr[%0d]", d), 32'(pgr_v[d]), 32'(m_gr[d]));
                chk($sformatf("pal_we_b[%0d]", d), 32'(pb_v[d]), 32'(m_b[d]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic en(input int d);
        return (pgr_v[d] != 2'b00) || pb_v[d];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cpu_we = 1'b0;
        LVBL   = 1'b1;
        LHBL   = 1'b1;
        rst_n  = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
    endtask

    task automatic push(input logic b, input logic [9:0] a, input logic [15:0] dt, input logic [1:0] s);
        cpu_we   = 1'b1;
        cpu_bank = b;
        cpu_addr = a;
        cpu_dout = dt;
        dsn      = s;
        tick();
        cpu_we   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        int         w;
        int         pct;
        logic [9:0] a_first;
        logic [9:0] a_last;

        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // reset while draining a 5-entry queue
        do_reset();
        for (int i = 0; i < 5; i++) push(1'b0, 10'h3F0 + 10'(i), 16'hF0F0 + 16'(i), 2'b00);
        chk("t1_pending5", 32'(pend_v[0]), 32'd5);
        LVBL = 1'b0;
        tick();
        tick();
        chk("t1_en_before_rst", 32'(en(0)), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_pending", 32'(pend_v[0]), 32'd0);
        chk("t1_rst_we_gr", 32'(pgr_v[0]), 32'd0);
        chk("t1_rst_addr", 32'(paddr_v[0]), 32'd0);
        chk("t1_rst_data", 32'(pdata_v[0]), 32'd0);
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n += int'(en(0)) + int'(en(1));
        end
        chk("t1_no_en_after_rst", 32'(n), 32'd0);
        LVBL = 1'b1;

        // single red/green write held until vertical blank
        do_reset();
        push(1'b0, 10'h123, 16'hABCD, 2'b00);
        chk("t2_pending1", 32'(pend_v[0]), 32'd1);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n += int'(en(0));
        end
        chk("t2_no_en_active", 32'(n), 32'd0);
        LVBL = 1'b0;
        tick();
        chk("t2_en_edge1", 32'(pgr_v[0]), 32'd0);
        tick();
        chk("t2_we_gr", 32'(pgr_v[0]), 32'h3);
        chk("t2_addr", 32'(paddr_v[0]), 32'h123);
        chk("t2_data", 32'(pdata_v[0]), 32'hABCD);
        tick();
        chk("t2_we_gr_off", 32'(pgr_v[0]), 32'd0);
        chk("t2_addr_hold", 32'(paddr_v[0]), 32'h123);
        LVBL = 1'b1;

        // blue write during blank: 3 cycles push to enable
        do_reset();
        LVBL = 1'b0;
        push(1'b1, 10'h055, 16'h0077, 2'b10);
        tick();
        chk("t3_b_k1", 32'(pb_v[0]), 32'd0);
        tick();
        chk("t3_b_k2", 32'(pb_v[0]), 32'd0);
        tick();
        chk("t3_b_k3", 32'(pb_v[0]), 32'd1);
        chk("t3_gr_k3", 32'(pgr_v[0]), 32'd0);
        chk("t3_data", 32'(pdata_v[0]), 32'h0077);
        tick();
        chk("t3_b_off", 32'(pb_v[0]), 32'd0);
        LVBL = 1'b1;

        // overflow: 17 pushes in active video
        do_reset();
        a_first = 10'($urandom);
        a_last  = '0;
        for (int i = 0; i < 17; i++) begin
            if (i == 0)       push(1'b0, a_first, 16'($urandom), 2'b00);
            else if (i == 15) begin a_last = 10'($urandom); push(1'b0, a_last, 16'($urandom), 2'b01); end
            else              push(1'($urandom), 10'($urandom), 16'($urandom), 2'b00);
            if (i == 15) begin
                chk("t4_full16", 32'(full_v[0]), 32'd1);
                chk("t4_ovf16", 32'(ovf_v[0]), 32'd0);
            end
        end
        chk("t4_ovf17", 32'(ovf_v[0]), 32'd1);
        chk("t4_pending16", 32'(pend_v[0]), 32'd16);
        LVBL = 1'b0;
        w = 0;
        while (!en(0) && w < 6) begin tick(); w++; end
        chk("t4_first_en_seen", 32'(en(0)), 32'd1);
        chk("t4_first_addr", 32'(paddr_v[0]), 32'(a_first));
        n = 0;
        while (en(0) && n < 40) begin
            n++;
            if (n == 16) chk("t4_last_addr", 32'(paddr_v[0]), 32'(a_last));
            tick();
        end
        chk("t4_run16", 32'(n), 32'd16);
        chk("t4_pending0", 32'(pend_v[0]), 32'd0);
        chk("t4_ovf_sticky", 32'(ovf_v[0]), 32'd1);
        LVBL = 1'b1;

        // horizontal blank ends mid-drain
        do_reset();
        for (int i = 0; i < 8; i++) push(1'b0, 10'h200 + 10'(i), 16'($urandom), 2'b00);
        LHBL = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin tick(); n += int'(en(1)); end
        LHBL = 1'b1;
        tick();
        n += int'(en(1));
        chk("t5_pops4", 32'(n), 32'd4);
        chk("t5_pending_h4", 32'(pend_v[1]), 32'd4);
        chk("t5_pending_v8", 32'(pend_v[0]), 32'd8);
        chk("t5_addr4", 32'(paddr_v[1]), 32'h203);
        tick();
        LHBL = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin tick(); n += int'(en(1)); end
        LHBL = 1'b1;
        chk("t5_rest4", 32'(n), 32'd4);
        chk("t5_pending_h0", 32'(pend_v[1]), 32'd0);

        // push every cycle of a 10-cycle blank with 3 queued
        do_reset();
        for (int i = 0; i < 3; i++) push(1'b0, 10'(i), 16'($urandom), 2'b00);
        LVBL = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            cpu_we   = 1'b1;
            cpu_bank = 1'b0;
            cpu_addr = 10'h100 + 10'(i);
            cpu_dout = 16'($urandom);
            dsn      = 2'b00;
            tick();
            n += int'(en(0));
            chk("t6_pending4", 32'(pend_v[0]), 32'd4);
        end
        cpu_we = 1'b0;
        LVBL   = 1'b1;
        chk("t6_en9", 32'(n), 32'd9);
        chk("t6_no_ovf", 32'(ovf_v[0]), 32'd0);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            case (c / 500)
                0: pct = 30;
                1: pct = 90;
                2: pct = 10;
                3: pct = 60;
                4: pct = 95;
                default: pct = 40;
            endcase
            cpu_we   = ($urandom_range(0, 99) < pct);
            cpu_bank = 1'($urandom);
            cpu_addr = 10'($urandom);
            cpu_dout = 16'($urandom);
            dsn      = 2'($urandom);
            if ($urandom_range(0, 29) == 0) LVBL = ~LVBL;
            if ($urandom_range(0, 5) == 0)  LHBL = ~LHBL;
            if (c == 1500) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            tick();
        end
        cpu_we = 1'b0;
        LVBL   = 1'b0;
        repeat (40) tick();
        chk("final_empty_v", 32'(pend_v[0]), 32'd0);
        chk("final_empty_h", 32'(pend_v[1]), 32'd0);
        LVBL = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
